// File: rtl/route_compute_unit_pkg.sv
// Shared switch types: head-flit layout, routing-table entry and the
// helper that pulls the destination node ID out of a header flit.
package route_compute_unit_pkg;

    localparam int MAX_ID_W = 8;

    typedef enum logic [1:0] {
        FLIT_HEAD   = 2'd0,
        FLIT_BODY   = 2'd1,
        FLIT_TAIL   = 2'd2,
        FLIT_SINGLE = 2'd3
    } flit_kind_e;

    typedef struct packed {
        flit_kind_e            kind;
        logic [MAX_ID_W-1:0]   dest;
        logic [21:0]           payload;
    } flit_t;

    typedef struct packed {
        logic                  vld;
        logic [MAX_ID_W-1:0]   port;
    } route_entry_t;

    function automatic logic [MAX_ID_W-1:0] flit_dest(input flit_t f);
        return f.dest;
    endfunction

endpackage

// File: rtl/route_compute_unit_rr_arbiter.sv
// Combinational round-robin picker: first requester after `last_i`
// (wrapping), skipping any bit set in `mask_i`. Shared with the allocator.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [N-1:0] mask_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] grant_o,
    output logic         valid_o
);

    logic [W-1:0] idx;

    always_comb begin
        // NOTE: every output gets a default before the search so no latch is inferred.
        grant_o = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int k = 1; k <= N; k++) begin
            idx = W'((int'(last_i) + k) % N);
            if (!valid_o && req_i[idx] && !mask_i[idx]) begin
                valid_o = 1'b1;
                grant_o = idx;
            end
        end
    end

endmodule

// File: rtl/route_compute_unit.sv
// Registered route-compute stage: round-robin over header requests, table
// or local-ID lookup, result held under a valid/ready handshake.
module route_compute_unit
    import route_compute_unit_pkg::*;
#(
    parameter int BUFFERS    = 4,
    parameter int OUTPORTS   = 4,
    parameter int NODES      = 32,
    parameter int LOCAL_PORT = 0
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  flit_t                         in_flit [BUFFERS],
    input  logic [BUFFERS-1:0]            req,
    output logic                          route_valid,
    input  logic                          route_ready,
    output logic [$clog2(BUFFERS)-1:0]    buffer_sel,
    output logic [$clog2(OUTPORTS)-1:0]   out_sel,
    output logic                          route_err,
    input  logic                          cfg_we,
    input  logic [$clog2(NODES)-1:0]      cfg_addr,
    input  logic [$clog2(OUTPORTS)-1:0]   cfg_port,
    input  logic                          cfg_vld,
    input  logic                          id_we,
    input  logic [$clog2(NODES)-1:0]      id_data,
    output logic [$clog2(NODES)-1:0]      id
);

    localparam int BW = $clog2(BUFFERS);
    localparam int OW = $clog2(OUTPORTS);
    localparam int NW = $clog2(NODES);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [BW-1:0]       sel_q, sel_d;
    logic [BW-1:0]       last_q, last_d;
    logic [OW-1:0]       out_q, out_d;
    logic                err_q, err_d;
    logic [NW-1:0]       id_q;
    route_entry_t        table_q [NODES];

    logic                handshake;
    logic                arb_en;
    logic [BUFFERS-1:0]  hs_mask;
    logic [BW-1:0]       grant;
    logic                grant_vld;
    logic [MAX_ID_W-1:0] dest_full;
    route_entry_t        entry;
    logic                unused_bits;

    assign handshake = (state_q == ST_HOLD) && route_ready;
    assign arb_en    = (state_q == ST_EMPTY) || route_ready;

    // The buffer being consumed on this edge still shows req high; hide it.
    always_comb begin
        hs_mask = '0;
        if (handshake) hs_mask[sel_q] = 1'b1;
    end

    rr_arbiter #(.N(BUFFERS), .W(BW)) u_arb (
        .req_i   (req),
        .mask_i  (hs_mask),
        .last_i  (last_q),
        .grant_o (grant),
        .valid_o (grant_vld)
    );

    assign dest_full   = flit_dest(in_flit[grant]);
    assign entry       = table_q[dest_full[NW-1:0]];
    assign unused_bits = ^{in_flit[grant], entry.port};

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        out_d   = out_q;
        err_d   = err_q;
        if (arb_en) begin
            if (grant_vld) begin
                state_d = ST_HOLD;
                sel_d   = grant;
                last_d  = grant;
                if (dest_full == MAX_ID_W'(id_q)) begin
                    out_d = OW'(LOCAL_PORT);
                    err_d = 1'b0;
                end else if (entry.vld) begin
                    out_d = entry.port[OW-1:0];
                    err_d = 1'b0;
                end else begin
                    out_d = '0;
                    err_d = 1'b1;
                end
            end else begin
                state_d = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_EMPTY;
            sel_q   <= '0;
            last_q  <= BW'(BUFFERS - 1);
            out_q   <= '0;
            err_q   <= 1'b0;
            id_q    <= '0;
            // NOTE: the table is reset on purpose; stale valid bits after reset would misroute.
            for (int n = 0; n < NODES; n++) table_q[n] <= '0;
        end else begin
            // NOTE: non-blocking so the lookup above sees the pre-edge table and ID.
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            out_q   <= out_d;
            err_q   <= err_d;
            if (cfg_we) table_q[cfg_addr] <= '{vld: cfg_vld, port: MAX_ID_W'(cfg_port)};
            if (id_we)  id_q <= id_data;
        end
    end

    assign route_valid = (state_q == ST_HOLD);
    assign buffer_sel  = sel_q;
    assign out_sel     = out_q;
    assign route_err   = err_q;
    assign id          = id_q;

endmodule

// File: tb/tb_route_compute_unit.sv
// Self-checking bench: directed scenarios pinned with literal expectations,
// then randomized traffic compared cycle-by-cycle against a behavioural model.
module tb_route_compute_unit;
    import route_compute_unit_pkg::*;

    localparam int BUFFERS    = 4;
    localparam int OUTPORTS   = 4;
    localparam int NODES      = 32;
    localparam int LOCAL_PORT = 1;
    localparam int BW = $clog2(BUFFERS);
    localparam int OW = $clog2(OUTPORTS);
    localparam int NW = $clog2(NODES);

    logic               CLK = 1'b0;
    logic               RST;
    flit_t              in_flit [BUFFERS];
    logic [BUFFERS-1:0] req;
    logic               route_valid;
    logic               route_ready;
    logic [BW-1:0]      buffer_sel;
    logic [OW-1:0]      out_sel;
    logic               route_err;
    logic               cfg_we;
    logic [NW-1:0]      cfg_addr;
    logic [OW-1:0]      cfg_port;
    logic               cfg_vld;
    logic               id_we;
    logic [NW-1:0]      id_data;
    logic [NW-1:0]      id;

    route_compute_unit #(
        .BUFFERS(BUFFERS), .OUTPORTS(OUTPORTS), .NODES(NODES), .LOCAL_PORT(LOCAL_PORT)
    ) dut (
        .CLK(CLK), .RST(RST), .in_flit(in_flit), .req(req),
        .route_valid(route_valid), .route_ready(route_ready),
        .buffer_sel(buffer_sel), .out_sel(out_sel), .route_err(route_err),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_port(cfg_port), .cfg_vld(cfg_vld),
        .id_we(id_we), .id_data(id_data), .id(id)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic flit_t mk(input int d);
        flit_t f;
        f.kind    = FLIT_HEAD;
        f.dest    = MAX_ID_W'(d);
        f.payload = 22'($urandom);
        return f;
    endfunction

    // Behavioural model: one held result, a plain table of (valid, port), and
    // the index of the most recently granted buffer.
    bit m_valid;
    int m_sel, m_out, m_id, m_last, m_hs_buf;
    bit m_err;
    bit m_tvld  [NODES];
    int m_tport [NODES];

    always @(posedge CLK or posedge RST) begin
        bit hs;
        int pick, b, d;
        if (RST) begin
            m_valid = 0; m_sel = 0; m_out = 0; m_err = 0; m_id = 0;
            m_last = BUFFERS - 1; m_hs_buf = -1;
            foreach (m_tvld[n]) m_tvld[n] = 0;
        end else begin
            hs       = m_valid && route_ready;
            m_hs_buf = hs ? m_sel : -1;
            pick     = -1;
            if (!m_valid || route_ready) begin
                for (int k = 1; k <= BUFFERS; k++) begin
                    b = (m_last + k) % BUFFERS;
                    if (pick < 0 && req[b] && b != m_hs_buf) pick = b;
                end
                if (pick >= 0) begin
                    d = int'(in_flit[pick].dest);
                    m_valid = 1; m_sel = pick; m_last = pick;
                    if (d == m_id)          begin m_out = LOCAL_PORT;  m_err = 0; end
                    else if (m_tvld[d])     begin m_out = m_tport[d];  m_err = 0; end
                    else                    begin m_out = 0;           m_err = 1; end
                end else begin
                    m_valid = 0;
                end
            end
            if (cfg_we) begin
                m_tvld[cfg_addr]  = cfg_vld;
                m_tport[cfg_addr] = int'(cfg_port);
            end
            if (id_we) m_id = int'(id_data);
        end
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            check("model_valid", route_valid, m_valid);
            check("model_id", id, m_id);
            if (m_valid) begin
                check("model_sel", buffer_sel, m_sel);
                check("model_out", out_sel, m_out);
                check("model_err", route_err, m_err);
            end
        end
    end

    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic route_one(input int b, input int d, input int exp_out, input int exp_err, input string tag);
        in_flit[b] = mk(d);
        req = '0;
        req[b] = 1'b1;
        cyc();
        check({tag, "_valid"}, route_valid, 1);
        check({tag, "_sel"}, buffer_sel, b);
        check({tag, "_out"}, out_sel, exp_out);
        check({tag, "_err"}, route_err, exp_err);
        route_ready = 1'b1;
        cyc();
        check({tag, "_drain"}, route_valid, 0);
        req = '0;
        route_ready = 1'b0;
    endtask

    initial begin
        RST = 1'b1; req = '1; route_ready = 1'b0;
        cfg_we = 0; cfg_addr = '0; cfg_port = '0; cfg_vld = 0;
        id_we = 0; id_data = '0;
        for (int b = 0; b < BUFFERS; b++) in_flit[b] = mk(0);
        cyc(); cyc();
        cmp_en = 1'b1;
        check("rst_valid", route_valid, 0);
        check("rst_id", id, 0);
        RST = 1'b0;
        cyc();
        check("first_valid", route_valid, 1);
        check("first_sel", buffer_sel, 0);
        check("first_local", out_sel, LOCAL_PORT);
        req = '0; route_ready = 1'b1;
        cyc();
        check("first_drain", route_valid, 0);
        route_ready = 1'b0;

        cfg_we = 1; cfg_addr = 5; cfg_port = 3; cfg_vld = 1;
        id_we = 1; id_data = 2;
        cyc();
        cfg_we = 0; id_we = 0;
        check("id_written", id, 2);
        route_one(1, 5, 3, 0, "table");
        route_one(2, 2, LOCAL_PORT, 0, "local");
        route_one(3, 7, 0, 1, "miss");

        // Back-to-back round robin; each buffer drops req for one cycle after its handshake.
        for (int b = 0; b < BUFFERS; b++) in_flit[b] = mk(5);
        req = 4'b1011; route_ready = 1'b1;
        cyc(); check("rr0_sel", buffer_sel, 0);
        req[0] = 1'b0;
        cyc(); check("rr1_sel", buffer_sel, 1);
        req[1] = 1'b0; req[0] = 1'b1;
        cyc(); check("rr2_sel", buffer_sel, 3);
        req[3] = 1'b0; req[1] = 1'b1;
        cyc(); check("rr3_sel", buffer_sel, 0);
        req = '0;
        cyc(); check("rr_drain", route_valid, 0);

        // Stall: outputs frozen while req and table[5] churn.
        in_flit[2] = mk(5); req = 4'b0100; route_ready = 1'b0;
        cyc();
        check("stall_sel", buffer_sel, 2);
        check("stall_out", out_sel, 3);
        for (int i = 0; i < 5; i++) begin
            req = BUFFERS'($urandom);
            cfg_we = 1; cfg_addr = 5; cfg_port = OW'((i + 1) % 4); cfg_vld = 1;
            cyc();
            check("stall_hold_valid", route_valid, 1);
            check("stall_hold_sel", buffer_sel, 2);
            check("stall_hold_out", out_sel, 3);
        end
        cfg_we = 0;
        in_flit[0] = mk(5); in_flit[3] = mk(5);
        req = 4'b1011; route_ready = 1'b1;
        cyc();
        check("post_stall_sel", buffer_sel, 3);
        check("post_stall_out", out_sel, 1);

        // Asynchronous reset between edges while holding buffer 3.
        route_ready = 1'b0; req = 4'b1000;
        cyc();
        check("pre_rst_valid", route_valid, 1);
        #2 RST = 1'b1;
        #1 check("async_rst_valid", route_valid, 0);
        #1 RST = 1'b0;
        cyc();
        check("rearb_sel", buffer_sel, 3);
        check("rearb_err_table_cleared", route_err, 1);
        check("rearb_out", out_sel, 0);

        // Randomized traffic against the model.
        req = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < BUFFERS; b++) begin
                if (m_hs_buf == b) req[b] = 1'b0;
                else if (!req[b] && $urandom_range(2) == 0) begin
                    in_flit[b] = mk(($urandom_range(1) == 0) ? $urandom_range(NODES - 1) : $urandom_range(7));
                    req[b] = 1'b1;
                end
            end
            route_ready = ($urandom_range(3) != 0);
            cfg_we   = ($urandom_range(3) == 0);
            cfg_addr = NW'($urandom_range(NODES - 1));
            cfg_port = OW'($urandom);
            cfg_vld  = 1'($urandom);
            id_we    = ($urandom_range(15) == 0);
            id_data  = NW'($urandom_range(7));
            cyc();
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
